// File: rtl/pwm_multichannel_generator_if.sv
// Host-side bundle for the multi-channel PWM generator: frequency select,
// packed duty values with their load strobes, per-channel enables, and the
// registered PWM outputs plus the period-start pulse.
interface pwm_multichannel_generator_if #(
   parameter int CHANNELS = 4,
   parameter int DUTY_W   = 8
);
   logic [2:0]                       Select;
   logic                             SelLoad;
   logic [CHANNELS-1:0][DUTY_W-1:0]  Duty;
   logic                             DutyLoad;
   logic [CHANNELS-1:0]              Enable;
   logic [CHANNELS-1:0]              OutputPWM;
   logic                             PeriodStart;

   modport master (
      output Select, SelLoad, Duty, DutyLoad, Enable,
      input  OutputPWM, PeriodStart
   );

   modport slave (
      input  Select, SelLoad, Duty, DutyLoad, Enable,
      output OutputPWM, PeriodStart
   );
endinterface

// File: rtl/pwm_multichannel_generator.sv
// Multi-channel PWM generator: one shared prescaler and period counter,
// per-channel duty compare. Select and duty updates are double-buffered and
// switch over only at the period boundary so outputs never glitch.

// Per-channel compare and output register.
module pwm_lane #(
   parameter int DUTY_W = 8
) (
   input  logic              CLK,
   input  logic              _RST,
   input  logic [DUTY_W-1:0] cnt_nxt,
   input  logic [DUTY_W-1:0] duty_nxt,
   input  logic              en,
   output logic              pwm_q
);
   // Compare against next-cycle counter/duty so the output edge lines up
   // with PeriodStart; full-scale duty means constant high.
   logic cmp;
   assign cmp = en && ((cnt_nxt < duty_nxt) || (duty_nxt == '1));

   // Register the compare result.
   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) pwm_q <= 1'b0;
      else       pwm_q <= cmp;
   end
endmodule

module pwm_multichannel_generator #(
   parameter int CLK_HZ   = 50000000,
   parameter int CHANNELS = 4,
   parameter int DUTY_W   = 8
) (
   input  logic                        CLK,
   input  logic                        _RST,
   pwm_multichannel_generator_if.slave bus
);
   // Clocks per period-counter tick for a given output frequency.
   function automatic logic [31:0] presc_of(input int f);
      longint q;
      q = longint'(CLK_HZ) / (longint'(f) << DUTY_W);
      if (q < 1) q = 1;
      return q[31:0];
   endfunction

   localparam logic [31:0] PRESC0 = presc_of(50);
   localparam logic [31:0] PRESC1 = presc_of(120);
   localparam logic [31:0] PRESC2 = presc_of(200);
   localparam logic [31:0] PRESC3 = presc_of(400);
   localparam logic [31:0] PRESC4 = presc_of(1000);
   localparam logic [31:0] PRESC5 = presc_of(2000);
   localparam logic [31:0] PRESC6 = presc_of(4000);
   localparam logic [2:0]  SEL_DEF = 3'd6;

   logic [31:0]                     pc, pc_nxt, presc_act;
   logic [DUTY_W-1:0]               cnt, cnt_nxt;
   logic [2:0]                      sel_act, sel_pend, sel_in;
   logic [2:0]                      sel_act_nxt, sel_pend_nxt;
   logic [CHANNELS-1:0][DUTY_W-1:0] duty_act, duty_pend;
   logic [CHANNELS-1:0][DUTY_W-1:0] duty_act_nxt, duty_pend_nxt;
   logic                            tick, boundary, period_start_q;
   logic [CHANNELS-1:0]             pwm_q;

   // Prescale value of the active select (code 7 never reaches here).
   always_comb begin
      presc_act = PRESC6;
      case (sel_act)
         3'd0:    presc_act = PRESC0;
         3'd1:    presc_act = PRESC1;
         3'd2:    presc_act = PRESC2;
         3'd3:    presc_act = PRESC3;
         3'd4:    presc_act = PRESC4;
         3'd5:    presc_act = PRESC5;
         default: presc_act = PRESC6;
      endcase
   end

   // Counter advance and double-buffer update. A load in the boundary cycle
   // lands in pending and is copied through to active on the same edge.
   always_comb begin
      tick          = (pc == presc_act - 32'd1);
      boundary      = tick && (cnt == '1);
      pc_nxt        = tick ? 32'd0 : pc + 32'd1;
      cnt_nxt       = tick ? cnt + DUTY_W'(1) : cnt;
      sel_in        = (bus.Select == 3'd7) ? 3'd6 : bus.Select;
      sel_pend_nxt  = bus.SelLoad ? sel_in : sel_pend;
      sel_act_nxt   = boundary ? sel_pend_nxt : sel_act;
      duty_pend_nxt = bus.DutyLoad ? bus.Duty : duty_pend;
      duty_act_nxt  = boundary ? duty_pend_nxt : duty_act;
   end

   // Shared counter, select and duty state.
   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         pc             <= '0;
         cnt            <= '0;
         sel_act        <= SEL_DEF;
         sel_pend       <= SEL_DEF;
         duty_act       <= '0;
         duty_pend      <= '0;
         period_start_q <= 1'b0;
      end else begin
         pc             <= pc_nxt;
         cnt            <= cnt_nxt;
         sel_act        <= sel_act_nxt;
         sel_pend       <= sel_pend_nxt;
         duty_act       <= duty_act_nxt;
         duty_pend      <= duty_pend_nxt;
         period_start_q <= boundary;
      end
   end

   for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
      pwm_lane #(.DUTY_W(DUTY_W)) u_lane (
         .CLK      (CLK),
         ._RST     (_RST),
         .cnt_nxt  (cnt_nxt),
         .duty_nxt (duty_act_nxt[n]),
         .en       (bus.Enable[n]),
         .pwm_q    (pwm_q[n])
      );
   end

   assign bus.OutputPWM   = pwm_q;
   assign bus.PeriodStart = period_start_q;
endmodule

// File: tb/tb_pwm_multichannel_generator.sv
// Bench for pwm_multichannel_generator. Runs at a reduced CLK_HZ so that the
// 50 Hz setting fits in a short run: PRESC(4000 Hz)=2 (period 512 clk),
// PRESC(50 Hz)=160 (period 40960 clk). A monitor measures each complete
// period (length and per-channel high time); tests push expected records and
// pop/compare against measured ones.
module tb_pwm_multichannel_generator;
   localparam int CH     = 4;
   localparam int W      = 8;
   localparam int CLK_HZ = 2048000;
   localparam int P6     = 512;
   localparam int LIMIT  = 50000;

   typedef struct packed {
      logic [31:0]         len;
      logic [3:0][31:0]    hi;
   } meas_t;

   logic CLK = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   meas_t obs_q[$];
   meas_t exp_q[$];
   meas_t cur;
   bit    started = 1'b0;

   always #5 CLK = ~CLK;

   pwm_multichannel_generator_if #(.CHANNELS(CH), .DUTY_W(W)) bus ();

   pwm_multichannel_generator #(.CLK_HZ(CLK_HZ), .CHANNELS(CH), .DUTY_W(W)) dut (
      .CLK  (CLK),
      ._RST (rst_n),
      .bus  (bus)
   );

   // Period monitor: a record covers PeriodStart up to the next PeriodStart.
   always @(negedge CLK) begin
      if (!rst_n) started = 1'b0;
      else begin
         if (bus.PeriodStart) begin
            if (started) obs_q.push_back(cur);
            started = 1'b1;
            cur = '0;
         end
         if (started) begin
            cur.len = cur.len + 1;
            for (int c = 0; c < CH; c++)
               if (bus.OutputPWM[c]) cur.hi[c] = cur.hi[c] + 1;
         end
      end
   end

   function automatic meas_t mk(input int len, input int h0, input int h1,
                                input int h2, input int h3);
      meas_t m;
      m.len = len; m.hi[0] = h0; m.hi[1] = h1; m.hi[2] = h2; m.hi[3] = h3;
      return m;
   endfunction

   task automatic wait_ps(input int limit, output int n);
      n = 0;
      do begin
         @(posedge CLK); #1; n++;
      end while (!bus.PeriodStart && n < limit);
      if (!bus.PeriodStart) begin
         checks++; errors++;
         $display("FAIL wait_ps_timeout got no PeriodStart in %0d clk", limit);
      end
   endtask

   task automatic sync_period();
      int n;
      wait_ps(LIMIT, n);
      @(negedge CLK); #1;
      obs_q.delete();
   endtask

   task automatic get_meas(output meas_t m);
      int n = 0;
      while (obs_q.size() == 0 && n < LIMIT) begin
         @(negedge CLK); #1; n++;
      end
      if (obs_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL meas_timeout got no period record in %0d clk", LIMIT);
         m = '0;
      end else m = obs_q.pop_front();
   endtask

   task automatic pulse_duty(input logic [3:0][7:0] d);
      bus.Duty = d; bus.DutyLoad = 1'b1;
      @(posedge CLK); #1;
      bus.DutyLoad = 1'b0;
   endtask

   task automatic pulse_sel(input logic [2:0] s);
      bus.Select = s; bus.SelLoad = 1'b1;
      @(posedge CLK); #1;
      bus.SelLoad = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      meas_t o, e;
      rst_n = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      checks++;
      if (bus.OutputPWM !== 4'b0000) begin
         errors++; $display("FAIL reset_out got %b want 0000", bus.OutputPWM);
      end
      checks++;
      if (bus.PeriodStart !== 1'b0) begin
         errors++; $display("FAIL reset_ps got %b want 0", bus.PeriodStart);
      end
      rst_n = 1'b1;
      wait_ps(2000, n);
      checks++;
      if (n != P6) begin
         errors++; $display("FAIL reset_first_ps got %0d want %0d", n, P6);
      end
      @(negedge CLK); #1;
      obs_q.delete();
      exp_q.push_back(mk(P6, 0, 0, 0, 0));
      exp_q.push_back(mk(P6, 0, 0, 0, 0));
      repeat (2) begin
         get_meas(o); e = exp_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset_rec got len=%0d hi=%0d,%0d,%0d,%0d want len=%0d hi=%0d,%0d,%0d,%0d",
                     o.len, o.hi[0], o.hi[1], o.hi[2], o.hi[3], e.len, e.hi[0], e.hi[1], e.hi[2], e.hi[3]);
         end
      end
   endtask

   task automatic test_duty();
      meas_t o, e;
      pulse_duty({8'd1, 8'd0, 8'd255, 8'd128});
      sync_period();
      exp_q.push_back(mk(P6, 256, 512, 0, 2));
      exp_q.push_back(mk(P6, 256, 512, 0, 2));
      repeat (2) begin
         get_meas(o); e = exp_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL duty_rec got len=%0d hi=%0d,%0d,%0d,%0d want len=%0d hi=%0d,%0d,%0d,%0d",
                     o.len, o.hi[0], o.hi[1], o.hi[2], o.hi[3], e.len, e.hi[0], e.hi[1], e.hi[2], e.hi[3]);
         end
      end
   endtask

   task automatic test_select();
      int n;
      meas_t o, e;
      sync_period();
      repeat (100) @(posedge CLK);
      #1;
      pulse_sel(3'd0);
      exp_q.push_back(mk(P6, 256, 512, 0, 2));
      exp_q.push_back(mk(40960, 20480, 40960, 0, 160));
      wait_ps(LIMIT, n);
      repeat (100) @(posedge CLK);
      #1;
      pulse_sel(3'd7);
      exp_q.push_back(mk(P6, 256, 512, 0, 2));
      repeat (3) begin
         get_meas(o); e = exp_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL select_rec got len=%0d hi=%0d,%0d,%0d,%0d want len=%0d hi=%0d,%0d,%0d,%0d",
                     o.len, o.hi[0], o.hi[1], o.hi[2], o.hi[3], e.len, e.hi[0], e.hi[1], e.hi[2], e.hi[3]);
         end
      end
   endtask

   task automatic test_boundary_load();
      meas_t o, e;
      sync_period();
      repeat (P6 - 1) @(posedge CLK);
      #1;
      pulse_duty({8'd1, 8'd0, 8'd255, 8'd64});
      exp_q.push_back(mk(P6, 256, 512, 0, 2));
      exp_q.push_back(mk(P6, 128, 512, 0, 2));
      repeat (10) @(posedge CLK);
      #1;
      pulse_duty({8'd1, 8'd0, 8'd255, 8'd200});
      repeat (10) @(posedge CLK);
      #1;
      pulse_duty({8'd1, 8'd0, 8'd255, 8'd32});
      exp_q.push_back(mk(P6, 64, 512, 0, 2));
      repeat (3) begin
         get_meas(o); e = exp_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL boundary_rec got len=%0d hi=%0d,%0d,%0d,%0d want len=%0d hi=%0d,%0d,%0d,%0d",
                     o.len, o.hi[0], o.hi[1], o.hi[2], o.hi[3], e.len, e.hi[0], e.hi[1], e.hi[2], e.hi[3]);
         end
      end
   endtask

   task automatic test_enable();
      meas_t o, e;
      sync_period();
      repeat (20) @(posedge CLK);
      #1;
      checks++;
      if (bus.OutputPWM[0] !== 1'b1) begin
         errors++; $display("FAIL enable_pre got %b want 1", bus.OutputPWM[0]);
      end
      bus.Enable = 4'b1110;
      @(posedge CLK); #1;
      checks++;
      if (bus.OutputPWM[1:0] !== 2'b10) begin
         errors++; $display("FAIL enable_drop got %b want 10", bus.OutputPWM[1:0]);
      end
      repeat (9) @(posedge CLK);
      #1;
      bus.Enable = 4'b1111;
      @(posedge CLK); #1;
      checks++;
      if (bus.OutputPWM[0] !== 1'b1) begin
         errors++; $display("FAIL enable_resume got %b want 1", bus.OutputPWM[0]);
      end
      exp_q.push_back(mk(P6, 54, 512, 0, 2));
      exp_q.push_back(mk(P6, 64, 512, 0, 2));
      repeat (2) begin
         get_meas(o); e = exp_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL enable_rec got len=%0d hi=%0d,%0d,%0d,%0d want len=%0d hi=%0d,%0d,%0d,%0d",
                     o.len, o.hi[0], o.hi[1], o.hi[2], o.hi[3], e.len, e.hi[0], e.hi[1], e.hi[2], e.hi[3]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      meas_t o, e;
      sync_period();
      repeat (50) @(posedge CLK);
      #1;
      pulse_sel(3'd3);
      repeat (20) @(posedge CLK);
      #1;
      checks++;
      if (bus.OutputPWM[1] !== 1'b1) begin
         errors++; $display("FAIL rstmid_pre got %b want 1", bus.OutputPWM[1]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.OutputPWM, bus.PeriodStart} !== 5'b00000) begin
         errors++; $display("FAIL rstmid_async got %b want 00000", {bus.OutputPWM, bus.PeriodStart});
      end
      repeat (3) @(posedge CLK);
      #1;
      rst_n = 1'b1;
      wait_ps(2000, n);
      checks++;
      if (n != P6) begin
         errors++; $display("FAIL rstmid_first_ps got %0d want %0d", n, P6);
      end
      @(negedge CLK); #1;
      obs_q.delete();
      exp_q.push_back(mk(P6, 0, 0, 0, 0));
      get_meas(o); e = exp_q.pop_front(); checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL rstmid_rec got len=%0d hi=%0d,%0d,%0d,%0d want len=%0d hi=%0d,%0d,%0d,%0d",
                  o.len, o.hi[0], o.hi[1], o.hi[2], o.hi[3], e.len, e.hi[0], e.hi[1], e.hi[2], e.hi[3]);
      end
   endtask

   initial begin
      bus.Select   = 3'd0;
      bus.SelLoad  = 1'b0;
      bus.Duty     = '0;
      bus.DutyLoad = 1'b0;
      bus.Enable   = 4'b1111;
      test_reset();
      test_duty();
      test_select();
      test_boundary_load();
      test_enable();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pwm_multichannel_generator.md
# pwm_multichannel_generator

Parametrised multi-channel PWM generator for the PWM IO expander. One shared prescaler and period counter run at a selectable frequency (50, 120, 200, 400, 1000, 2000 or 4000 Hz). Each of CHANNELS outputs has its own duty value. Duty and frequency changes are double-buffered and take effect only at a period boundary, so outputs never glitch. The block sits between the host register interface and the expander output pins.

## Interface
- CLK_HZ, 50000000, input clock frequency in Hz
- CHANNELS, 4, number of PWM outputs (1..16)
- DUTY_W, 8, duty and period-counter width; one period = 2^DUTY_W ticks
- CLK  input  1  system clock, all logic on rising edge
- _RST  input  1  asynchronous, active-low reset
- Select  input  3  frequency code: 0=50, 1=120, 2=200, 3=400, 4=1000, 5=2000, 6=4000 Hz; 7 is treated as 6
- SelLoad  input  1  one-cycle strobe that captures Select into the pending register
- Duty  input  CHANNELS*DUTY_W  packed duty values; channel n is bits [n*DUTY_W +: DUTY_W]
- DutyLoad  input  1  one-cycle strobe that captures all of Duty into the pending registers
- Enable  input  CHANNELS  per-channel output enable
- OutputPWM  output  CHANNELS  PWM outputs, registered
- PeriodStart  output  1  one-cycle pulse in the cycle the period counter wraps to 0

## Operation
- Prescale value per code: PRESC(f) = floor(CLK_HZ / (f * 2^DUTY_W)), clamped to a minimum of 1. Constants are computed at elaboration. The prescale counter is 32 bits.
- Examples at default parameters:
  - 4000 Hz: PRESC = 48, period = 12288 clk (≈4069 Hz).
  - 50 Hz: PRESC = 3906, period = 999936 clk.
- Prescale counter `pc` counts 0..PRESC_active-1. A tick occurs when pc = PRESC_active-1, and pc returns to 0 on that cycle.
- Period counter `cnt` (DUTY_W bits) increments on each tick. It wraps from 2^DUTY_W-1 to 0 on a tick; that tick is the boundary.
- At the boundary:
  - pending select is copied to active select;
  - pending duties are copied to active duties;
  - pc restarts at 0 using the new PRESC.
- A SelLoad or DutyLoad in the boundary cycle bypasses pending, so the new value is active for the period starting at that boundary.
- A load in any other cycle overwrites pending; the last load before the boundary wins.
- Output compare for channel n: high when Enable[n] and (cnt < duty_active[n], or duty_active[n] = all-ones). Result is registered into OutputPWM[n].
  - Duty 0 gives constant low.
  - Duty all-ones gives constant high (100%), not (2^DUTY_W-1)/2^DUTY_W.
- Enable is not buffered. Deasserting Enable[n] forces OutputPWM[n] low on the next clock. The counters keep running regardless of Enable.

## Timing
- Reset (async assert, values hold while _RST=0):
  - pc = 0, cnt = 0;
  - active and pending select = 6 (4000 Hz);
  - all active and pending duties = 0;
  - OutputPWM = 0, PeriodStart = 0.
- After _RST deasserts, counting starts on the first rising edge.
- Reset mid-period abandons the period and discards pending values.
- OutputPWM lags the compare by one clock. The output rises one clock after the boundary cycle.
- PeriodStart is registered and high for exactly one clock, aligned with the first cycle of the new period (same edge as the output rise).
- High time = duty_active * PRESC_active clocks. Period = 2^DUTY_W * PRESC_active clocks.
- Select code 7 behaves exactly as code 6, including at reset and on load.
- With PRESC = 1, cnt advances every clock and the period is 2^DUTY_W clocks.

## Test plan
- Reset defaults: hold _RST=0 for 5 clocks, release, run 2 periods → OutputPWM = 0, first PeriodStart 12288 clk after release, repeating every 12288 clk.
- Duty 128 on ch0, 255 on ch1, 0 on ch2, 1 on ch3 at 4000 Hz, all enabled → measured high/period:
  - ch0: 6144/12288
  - ch1: always high
  - ch2: always low
  - ch3: 48/12288
- Select=0 loaded mid-period → current period still 12288 clk, then periods of 999936 clk; ch0 duty 128 → high 499968 clk.
- DutyLoad with ch0 = 64 in the same cycle as a boundary → that period high 3072 clk. DutyLoad 200 then 32 within one period → next period uses 32 (1536 clk).
- Enable[0] dropped mid-high → OutputPWM[0] low next clock; cnt and PeriodStart spacing unaffected; re-enable resumes mid-period per compare.
- _RST pulsed low mid-period with pending Select=3 → outputs 0 immediately, frequency returns to 4000 Hz, pending discarded.
